decoder_scan_n: RTL
===================

// Module: decoder_scan_n
// PURPOSE
//  Parametrised, registered N-to-2^N one-hot decoder with enable and an optional scan mode.
//  Direct mode decodes the In bus.
//  Scan mode steps an internal index through outputs 0..scan_limit, holding each for (dwell+1) clocks.
//  Drives digit/anode selects of multiplexed displays and other one-hot select lines.
//  Replaces combinational 2-to-4 and 3-to-8 decoders where registered, glitch-free selects are needed.
// PARAMETERS
//  SEL_W      2   select width; NOUT = 2**SEL_W outputs (SEL_W 1..5)
//  DWELL_W    16  width of dwell-count input and internal dwell counter
//  ACTIVE_LOW 0   1: asserted output bit is 0, inactive outputs are 1
//  BLANK      0   1: outputs inactive during first clock of every scan step (anti-ghosting)
// PORTS
//  clk        in   1        rising-edge clock
//  resetn     in   1        asynchronous active-low reset
//  E          in   1        enable; 0 = all outputs inactive, scan state frozen
//  mode       in   1        0 = direct decode, 1 = scan
//  In         in   SEL_W    select to decode in direct mode
//  scan_limit in   SEL_W    highest index visited in scan mode
//  dwell      in   DWELL_W  clocks per scan step minus 1
//  Out        out  NOUT     registered one-hot (polarity per ACTIVE_LOW)
//  idx        out  SEL_W    index currently driven on Out
//  wrap       out  1        1-clock pulse when scan index returns from scan_limit to 0
// BEHAVIOUR
//  Reset (resetn=0, async):
//   - Out = all inactive (0s, or 1s if ACTIVE_LOW); idx = 0; wrap = 0.
//   - Dwell counter = 0; mode-history flop = 0 (direct).
//  All outputs registered; no combinational path from inputs to Out.
//  Direct mode (mode=0, E=1):
//   - Out <= onehot(In); idx <= In; one-clock latency; wrap = 0.
//   - Dwell counter is held at 0.
//  Scan mode (mode=1, E=1):
//   - Counter increments each clock.
//   - When counter >= dwell: counter <= 0 and idx advances.
//   - Advance rule: if idx >= scan_limit then idx <= 0 and wrap pulses 1 clock; else idx <= idx+1.
//   - Out <= onehot(next idx), registered with idx.
//   - Comparison uses >=, so lowering dwell or scan_limit mid-step takes effect at the next check.
//   - dwell = 0: idx advances every clock.
//  Direct->scan transition (mode rises while E=1):
//   - idx <= 0, counter <= 0, Out <= onehot(0).
//   - Scan restarts at 0; no wrap pulse.
//  Scan->direct transition: next clock behaves as direct mode; counter cleared.
//  E=0:
//   - Out <= all inactive next clock; wrap <= 0.
//   - idx and counter hold.
//   - E returning to 1 in scan mode resumes the same step and count.
//  BLANK=1 (scan mode only):
//   - Out is inactive on the clock where counter == 0 (first clock of each step).
//   - idx and wrap are still updated normally.
//   - With dwell = 0, Out stays permanently inactive.
//  scan_limit = 0: idx remains 0 and wrap pulses at every step boundary.
//  Out is always one-hot or all-inactive; never multi-hot.
// TESTING
//  1 Reset mid-scan, SEL_W=2: assert resetn=0 at idx=2 -> Out=0000, idx=0, wrap=0 immediately (no clk edge).
//  2 Direct, E=1, In=00,01,10,11 on successive clocks -> Out=0001,0010,0100,1000, each one clock later; E=0 -> Out=0000.
//  3 Scan, dwell=2, scan_limit=3:
//     - idx steps 0,1,2,3,0 every 3 clocks.
//     - wrap high exactly 1 clock, coincident with idx 3->0.
//  4 Scan, dwell=0, scan_limit=2 -> Out cycles 0001,0010,0100 every clock; scan_limit lowered to 1 while idx=2 -> next idx=0 with wrap.
//  5 E dropped for 5 clocks at idx=1, count=1 (dwell=3) -> Out inactive; after E=1, idx=1 held 2 more clocks, then advances.
//  6 ACTIVE_LOW=1, BLANK=1, SEL_W=3, dwell=1:
//     - Out alternates 11111111 (blank) and 11111110, then 11111101, ...
//     - Mode 1->0 with In=5 -> Out=11011111 next clock.

Source files
------------

// File: rtl/decoder_scan_n.sv
// -----------------------------------------------------------------------------
// decoder_scan_n
//
// Registered N-to-2^N one-hot decoder with enable and an optional scan mode.
// It drives glitch-free select lines, such as the digit or anode selects of a
// multiplexed display.
//
//   Direct mode (mode=0): Out and idx follow In, one clock later.
//   Scan mode   (mode=1): idx steps 0..scan_limit. Each index is held for
//                         (dwell+1) clocks. wrap pulses for one clock when idx
//                         returns from scan_limit to 0.
//
// Parameters
//   SEL_W      select width, 1..5; NOUT = 2**SEL_W outputs
//   DWELL_W    width of the dwell input and of the internal dwell counter
//   ACTIVE_LOW 1: the asserted output bit is 0 and inactive bits are 1
//   BLANK      1: in scan mode, Out is inactive on the first clock of each step
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   E          enable; 0 = Out inactive, scan state frozen
//   mode       0 = direct decode, 1 = scan
//   In         select decoded in direct mode
//   scan_limit highest index visited in scan mode
//   dwell      clocks per scan step minus 1
//   Out        registered one-hot select (polarity per ACTIVE_LOW)
//   idx        index currently driven on Out
//   wrap       1-clock pulse on the scan_limit -> 0 transition
// -----------------------------------------------------------------------------
module decoder_scan_n #(
  parameter  int SEL_W      = 2,
  parameter  int DWELL_W    = 16,
  parameter  int ACTIVE_LOW = 0,
  parameter  int BLANK      = 0,
  localparam int NOUT       = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               E,
  input  logic               mode,
  input  logic [SEL_W-1:0]   In,
  input  logic [SEL_W-1:0]   scan_limit,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NOUT-1:0]    Out,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  // Out value with no bit asserted, in the configured polarity.
  localparam logic [NOUT-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {NOUT{1'b1}} : {NOUT{1'b0}};

  // This flop records the mode that was seen on the last enabled clock.
  // A rise from direct to scan restarts the scan at index 0.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  mode_e              mode_q, mode_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NOUT-1:0]    out_q, out_d;
  logic               wrap_q, wrap_d;
  logic               show_d;   // 1: Out asserts the bit selected by idx_d

  // Active-high one-hot of an index. The polarity is applied afterwards.
  function automatic logic [NOUT-1:0] onehot(input logic [SEL_W-1:0] sel);
    onehot = NOUT'(1) << sel;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default value first. Then no path through the
  // if/else tree leaves a variable unassigned, and no latch is inferred.
  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    show_d = 1'b0;

    if (E) begin
      show_d = 1'b1;
      mode_d = mode ? MODE_SCAN : MODE_DIRECT;

      if (!mode) begin
        // Direct decode. The dwell counter stays cleared, so a later
        // scan always starts from a fresh step.
        idx_d = In;
        cnt_d = '0;
      end else if (mode_q == MODE_DIRECT) begin
        // Entering scan mode: restart at index 0 without a wrap pulse.
        idx_d = '0;
        cnt_d = '0;
      end else if (cnt_q >= dwell) begin
        // The step is complete. The >= compare means that lowering dwell or
        // scan_limit mid-step ends the step at the next check, so the
        // counter and index never run past the new limit.
        cnt_d = '0;
        if (idx_q >= scan_limit) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end

      // Anti-ghosting: blank the first clock of every scan step. The counter
      // is 0 on exactly that clock.
      if ((BLANK != 0) && mode && (cnt_d == '0)) begin
        show_d = 1'b0;
      end
    end
  end

  // Apply the polarity before the register. Out then comes straight from
  // a flop, in either polarity.
  assign out_d = show_d ? (onehot(idx_d) ^ INACTIVE) : INACTIVE;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever the statement order,
  // and the block matches the hardware it describes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= MODE_DIRECT;
      idx_q  <= '0;
      cnt_q  <= '0;
      out_q  <= INACTIVE;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign Out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
